hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. Drives the per-stage `stall` (load-enable) and flush inputs of the F/D/E/M/W pipeline registers. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits. A watchdog latches a fatal error when memory never acknowledges, and two saturating performance counters record stall and flush activity.

## Interface
Parameters:
- `RA_W`, 5: register-address width.
- `TIMEOUT`, 15: maximum WAIT-state cycles without `mem_ack` before the error state (must be ≥ 1, < 2^8).
- `CNT_W`, 16: performance-counter width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `rs1_d`, `rs2_d`  in  RA_W: source registers of the instruction in D.
- `rd_e`  in  RA_W: destination register of the instruction in E.
- `memread_e`  in  1: the instruction in E is a load.
- `pc_src_e`  in  1: a taken branch or jump resolved in E.
- `mem_req_m`  in  1: the instruction in M accesses data memory.
- `mem_ack`  in  1: data memory completes the access this cycle.
- `en_f`, `en_d`, `en_e`, `en_m`, `en_w`  out  1 each: pipeline-register load enables (1 = capture).
- `flush_d`, `flush_e`  out  1 each: synchronous clear of the D or E register to a bubble.
- `mem_err`  out  1: sticky watchdog error.
- `stall_cycles`  out  CNT_W: count of cycles with `en_f`=0 while in RUN or WAIT.
- `flush_count`  out  CNT_W: count of cycles with a branch flush.

## Operation
- State machine states: RUN, WAIT, ERR. Reset state is RUN.
- Definitions:
  - `lu` = `memread_e` & (`rd_e`≠0) & (`rd_e`==`rs1_d` | `rd_e`==`rs2_d`).
  - `mw` = `mem_req_m` & ~`mem_ack`.
- Output priority in RUN (highest first):
  1. `mw`: all `en_*`=0, both flushes 0. Transition to WAIT with `wait_cnt`←1.
  2. `pc_src_e`: all `en_*`=1, `flush_d`=1, `flush_e`=1. Branch overrides `lu` because the D instruction is wrong-path.
  3. `lu`: `en_f`=`en_d`=0, `en_e`=`en_m`=`en_w`=1, `flush_e`=1, `flush_d`=0.
  4. Otherwise: all `en_*`=1, both flushes 0.
- WAIT state:
  - With `mem_ack`=0: all `en_*`=0 and both flushes 0. If `wait_cnt`==TIMEOUT, go to ERR; otherwise `wait_cnt`+1.
  - With `mem_ack`=1: apply the RUN priority rules 2–4 to the current inputs, then go to RUN.
- ERR state: all `en_*`=0, flushes 0, `mem_err`=1. Leaves only on reset.
- Counters:
  - Both counters saturate at 2^CNT_W−1 and never wrap.
  - `flush_count` increments on each cycle where rule 2 fires.

## Timing
- `en_*` and `flush_*` are combinational from the inputs and current state, with zero-cycle latency. They are valid in the same cycle they gate the pipeline registers.
- `mem_err`, the counters, the state and `wait_cnt` are registered and update on the rising edge.
- While `reset`=0:
  - All outputs read 0: enables, flushes, `mem_err` and both counters.
  - The state is forced to RUN and `wait_cnt` to 0.
- Reset asserted mid-WAIT or in ERR aborts immediately, asynchronously.
- The first cycle after reset deassertion behaves as RUN.
- Frozen cycles before ERR with no ack: TIMEOUT+1. ERR becomes visible on the following cycle.
- An ack arriving in the same cycle that `wait_cnt`==TIMEOUT wins: the controller returns to RUN with no error.
- A `lu` or `pc_src_e` asserted during WAIT is not lost. The pipeline is frozen, so these inputs stay stable and take effect on the ack cycle.

## Structure
- `hazard_pkg`:
  - State enum (RUN=2'd0, WAIT=2'd1, ERR=2'd2).
  - Enable-vector bit indices for F..W.
- Sub-module `sat_counter` (parameter CNT_W; ports: `clk`, `reset`, `inc`, `q`), instantiated twice.
- The load-use comparator stays inline.

## Test plan
- Load-use: `memread_e`=1, `rd_e`=5, `rs2_d`=5 → `en_f`=`en_d`=0, `flush_e`=1 for one cycle. `stall_cycles` goes 0→1.
- Load-use with `rd_e`=0 (x0) and a register match → no stall, all `en_*`=1.
- Branch and load-use together: `pc_src_e`=1 and `lu`=1 → `flush_d`=`flush_e`=1, all `en_*`=1, `flush_count`=1.
- Memory wait: `mem_req_m`=1 with ack on the 3rd cycle → 2 frozen cycles (RUN→WAIT→ack), then RUN. `stall_cycles`=2.
- Watchdog: TIMEOUT=4, `mem_req_m`=1, `mem_ack` held 0 → 5 frozen cycles, `mem_err`=1 from cycle 6. Enables stay 0 until `reset` pulses low, after which everything reads 0 and the controller is back in RUN.
- Saturation: CNT_W=4 with 20 load-use stalls → `stall_cycles` holds at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
//------------------------------------------------------------------------------
// Module : hazard_pkg
// Purpose: Shared types and constants for the pipeline hazard controller:
//          controller state encoding and the bit positions of the per-stage
//          load-enable vector.
// Ports  : none (package)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  // Bit positions inside the enable vector, one per pipeline register.
  localparam int EN_NUM = 5;
  localparam int EN_F   = 0;
  localparam int EN_D   = 1;
  localparam int EN_E   = 2;
  localparam int EN_M   = 3;
  localparam int EN_W   = 4;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
//------------------------------------------------------------------------------
// Module : sat_counter
// Purpose: Up-counter that sticks at its all-ones maximum instead of wrapping.
// Ports  : clk   - clock, rising edge
//          reset - asynchronous active-low reset, clears the count
//          inc   - add one this cycle (ignored once saturated)
//          q     - current count
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (inc && (q != CNT_MAX)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module : hazard_ctrl
// Purpose: Sequencing controller for a 5-stage pipeline. Produces per-stage
//          load enables and D/E flushes to resolve load-use hazards,
//          taken-branch redirects and multi-cycle data-memory waits. A
//          watchdog latches a sticky error when memory never acknowledges;
//          two saturating counters record stall and flush activity.
// Ports  : clk, reset (async active-low)
//          rs1_d, rs2_d      - source registers of the D-stage instruction
//          rd_e, memread_e   - destination / load flag of the E-stage instr
//          pc_src_e          - taken branch/jump resolved in E
//          mem_req_m, mem_ack- M-stage memory request and its completion
//          en_f..en_w        - pipeline-register load enables (1 = capture)
//          flush_d, flush_e  - turn the D / E register into a bubble
//          mem_err           - sticky watchdog error
//          stall_cycles      - cycles with en_f low while RUN or WAIT
//          flush_count       - cycles with a branch flush
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W    = 5,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  rs1_d,
  input  logic [RA_W-1:0]  rs2_d,
  input  logic [RA_W-1:0]  rd_e,
  input  logic             memread_e,
  input  logic             pc_src_e,
  input  logic             mem_req_m,
  input  logic             mem_ack,
  output logic             en_f,
  output logic             en_d,
  output logic             en_e,
  output logic             en_m,
  output logic             en_w,
  output logic             flush_d,
  output logic             flush_e,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state;
  logic [7:0]        wait_cnt;

  logic              lu;
  logic              mw;
  logic              live;
  logic [EN_NUM-1:0] rule_en;
  logic              rule_fd;
  logic              rule_fe;
  logic              rule_br;
  logic [EN_NUM-1:0] en;
  logic              branch_fire;
  logic              stall_inc;

  // Load-use: E holds a load whose (non-x0) destination feeds D.
  assign lu = memread_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign mw = mem_req_m && !mem_ack;

  // Branch/load-use outcome, independent of whether the pipeline may advance.
  // The branch wins because the D instruction is on the wrong path anyway.
  always_comb begin
    rule_en = '1;
    rule_fd = 1'b0;
    rule_fe = 1'b0;
    rule_br = 1'b0;
    if (pc_src_e) begin
      rule_fd = 1'b1;
      rule_fe = 1'b1;
      rule_br = 1'b1;
    end else if (lu) begin
      rule_en[EN_F] = 1'b0;
      rule_en[EN_D] = 1'b0;
      rule_fe       = 1'b1;
    end
  end

  // live = the pipeline is allowed to move this cycle. In WAIT the ack cycle
  // applies the held-over branch/load-use inputs. Reset forces everything off.
  always_comb begin
    live = 1'b0;
    case (state)
      RUN:     live = !mw;
      WAIT:    live = mem_ack;
      default: live = 1'b0;
    endcase
    if (!reset) begin
      live = 1'b0;
    end
  end

  assign en          = live ? rule_en : '0;
  assign flush_d     = live && rule_fd;
  assign flush_e     = live && rule_fe;
  assign branch_fire = live && rule_br;

  assign en_f = en[EN_F];
  assign en_d = en[EN_D];
  assign en_e = en[EN_E];
  assign en_m = en[EN_M];
  assign en_w = en[EN_W];

  // Frozen cycles in ERR are not stall activity.
  assign stall_inc = !en[EN_F] && (state != ERR);

  // wait_cnt numbers the frozen cycles: the RUN cycle that detects the miss
  // is 1, so TIMEOUT+1 frozen cycles elapse before ERR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mw) begin
            state    <= WAIT;
            wait_cnt <= 8'd1;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == TIMEOUT_C) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ERR: begin
          mem_err <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .q     (stall_cycles)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branch_fire),
    .q     (flush_count)
  );

endmodule

`default_nettype wire
